// File: rtl/handshake_pkg.sv
// Shared constants and payload type for the registered valid/ready slice.
package handshake_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    typedef logic [DATA_WIDTH_DEFAULT-1:0] payload_t;

endpackage

// File: rtl/hs_slot.sv
// One storage slot of the slice: a valid flag plus its payload register.
module hs_slot
    import handshake_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Load wins over clear; the payload only changes on a load and otherwise holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/handshake_type3.sv
// Fully registered valid/ready skid buffer: main slot drives the outputs,
// skid slot catches the one item accepted while downstream ready propagates back.
module handshake_type3
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  valid_pre_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_pre_o,
    output logic                  valid_post_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_post_i
);

    logic                  main_valid;
    logic [DATA_WIDTH-1:0] main_data;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;

    logic                  in_xfer;
    logic                  out_xfer;
    logic                  main_take;
    logic                  main_load;
    logic                  main_clear;
    logic [DATA_WIDTH-1:0] main_next;
    logic                  skid_load;
    logic                  skid_clear;

    assign in_xfer  = valid_pre_i && !skid_valid;
    assign out_xfer = main_valid && ready_post_i;

    // Main refills whenever it is empty or draining; the skid item always goes first.
    always_comb begin
        main_take  = !main_valid || out_xfer;
        main_load  = main_take && (skid_valid || in_xfer);
        main_clear = main_take && !skid_valid && !in_xfer;
        main_next  = skid_valid ? skid_data : data_i;
        skid_load  = in_xfer && main_valid && !out_xfer;
        skid_clear = main_take && skid_valid;
    end

    hs_slot #(
        .WIDTH (DATA_WIDTH)
    ) u_main (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (main_load),
        .clear     (main_clear),
        .load_data (main_next),
        .valid     (main_valid),
        .data      (main_data)
    );

    hs_slot #(
        .WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (data_i),
        .valid     (skid_valid),
        .data      (skid_data)
    );

    assign valid_post_o = main_valid;
    assign data_o       = main_data;
    assign ready_pre_o  = !skid_valid;

endmodule

// File: tb/tb_handshake_type3.sv
// Self-checking bench for handshake_type3: directed vector table, streaming,
// randomized traffic against a two-entry queue model, and async reset checks.
module tb_handshake_type3;
    import handshake_pkg::*;

    logic     clk;
    logic     reset_n;
    logic     valid_pre_i;
    payload_t data_i;
    logic     ready_pre_o;
    logic     valid_post_o;
    payload_t data_o;
    logic     ready_post_i;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic     valid_pre;
        payload_t data;
        logic     ready_post;
        logic     exp_valid;
        payload_t exp_data;
        logic     exp_ready;
    } vector_t;

    vector_t vectors[17];

    handshake_type3 #(
        .DATA_WIDTH (DATA_WIDTH_DEFAULT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .valid_pre_i  (valid_pre_i),
        .data_i       (data_i),
        .ready_pre_o  (ready_pre_o),
        .valid_post_o (valid_post_o),
        .data_o       (data_o),
        .ready_post_i (ready_post_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change on the falling edge; the call returns at the next falling edge.
    task automatic apply_stimulus(input logic v, input payload_t d, input logic r);
        valid_pre_i  = v;
        data_i       = d;
        ready_post_i = r;
        @(negedge clk);
    endtask

    initial begin
        payload_t q[$];
        int next_send;
        int next_recv;
        int delivered;
        int cycles;
        logic v;
        logic r;
        logic in_x;
        logic out_x;
        logic prev_stall;
        payload_t prev_data;

        vectors[0]  = '{1'b1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b1};
        vectors[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b1};
        vectors[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1};
        vectors[3]  = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1};
        vectors[4]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0};
        vectors[5]  = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b0};
        vectors[6]  = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b0};
        vectors[7]  = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 1'b1};
        vectors[8]  = '{1'b0, 8'h44, 1'b1, 1'b0, 8'h22, 1'b1};
        vectors[9]  = '{1'b1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b1};
        vectors[10] = '{1'b1, 8'h66, 1'b0, 1'b1, 8'h55, 1'b0};
        vectors[11] = '{1'b1, 8'h77, 1'b1, 1'b1, 8'h66, 1'b1};
        vectors[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h66, 1'b1};
        vectors[13] = '{1'b1, 8'h88, 1'b1, 1'b1, 8'h88, 1'b1};
        vectors[14] = '{1'b1, 8'h99, 1'b1, 1'b1, 8'h99, 1'b1};
        vectors[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h99, 1'b1};
        vectors[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h99, 1'b1};

        reset_n      = 1'b0;
        valid_pre_i  = 1'b0;
        data_i       = '0;
        ready_post_i = 1'b0;
        repeat (5) @(negedge clk);
        check_output("reset_valid", valid_post_o, 1'b0);
        check_output("reset_data", data_o, 8'h00);
        check_output("reset_ready", ready_pre_o, 1'b1);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed vector table");
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vectors[i].valid_pre, vectors[i].data, vectors[i].ready_post);
            check_output($sformatf("vec%0d_valid", i), valid_post_o, vectors[i].exp_valid);
            check_output($sformatf("vec%0d_data", i), data_o, vectors[i].exp_data);
            check_output($sformatf("vec%0d_ready", i), ready_pre_o, vectors[i].exp_ready);
        end

        // Back-to-back streaming: item k+1 must be on the output right after edge k.
        $display("[TB] streaming 200 items");
        for (int c = 0; c < 202; c++) begin
            apply_stimulus(c < 200, payload_t'(c + 1), 1'b1);
            check_output($sformatf("stream%0d_valid", c), valid_post_o, c < 200);
            if (c < 200)
                check_output($sformatf("stream%0d_data", c), data_o, (c + 1) & 8'hFF);
        end

        $display("[TB] randomized traffic");
        next_send  = 1;
        next_recv  = 1;
        delivered  = 0;
        cycles     = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (delivered < 200 && cycles < 5000) begin
            check_output("rand_valid", valid_post_o, q.size() > 0);
            check_output("rand_ready", ready_pre_o, q.size() < 2);
            if (q.size() > 0)
                check_output("rand_data", data_o, q[0]);
            if (prev_stall) begin
                check_output("rand_stall_valid", valid_post_o, 1'b1);
                check_output("rand_stall_data", data_o, prev_data);
            end
            v     = 1'($urandom_range(0, 1));
            r     = 1'($urandom_range(0, 1));
            in_x  = v && (q.size() < 2);
            out_x = r && (q.size() > 0);
            prev_stall = (q.size() > 0) && !r;
            prev_data  = data_o;
            if (out_x) begin
                check_output("rand_order", data_o, next_recv & 8'hFF);
                next_recv++;
                delivered++;
                void'(q.pop_front());
            end
            if (in_x)
                q.push_back(payload_t'(next_send));
            apply_stimulus(v, v ? payload_t'(next_send) : payload_t'($urandom), r);
            if (in_x)
                next_send++;
            cycles++;
        end
        check_output("rand_delivered", delivered, 200);

        // Fill both slots, then pull reset between clock edges.
        $display("[TB] mid-operation async reset");
        apply_stimulus(1'b1, 8'hA1, 1'b0);
        apply_stimulus(1'b1, 8'hA2, 1'b0);
        check_output("prerst_ready", ready_pre_o, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("async_rst_valid", valid_post_o, 1'b0);
        check_output("async_rst_data", data_o, 8'h00);
        check_output("async_rst_ready", ready_pre_o, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        apply_stimulus(1'b1, 8'hB1, 1'b1);
        check_output("postrst_valid", valid_post_o, 1'b1);
        check_output("postrst_data", data_o, 8'hB1);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("postrst_drain", valid_post_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
